// File: rtl/trace_capture_buffer_pkg.sv
// Shared types for the trace capture buffer: trigger modes and capture FSM states.
package trace_capture_buffer_pkg;

    // Trigger source selection; encoding 3 behaves like TRIG_EXT
    typedef enum logic [1:0] {
        TRIG_IMM   = 2'd0,
        TRIG_MATCH = 2'd1,
        TRIG_EXT   = 2'd2
    } trace_trig_mode_t;

    // Capture lifecycle
    typedef enum logic [1:0] {
        TC_IDLE      = 2'd0,
        TC_ARMED     = 2'd1,
        TC_TRIGGERED = 2'd2,
        TC_DONE      = 2'd3
    } trace_cap_state_t;

    localparam int TC_DEFAULT_DATA_W  = 64;
    localparam int TC_DEFAULT_DEPTH   = 256;
    localparam int TC_DEFAULT_CYCLE_W = 32;

endpackage

// File: rtl/trace_capture_mem.sv
// Trace record storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. With TRACE_CAPTURE_TS_EN defined each entry holds
// {timestamp, payload}; otherwise only the payload is stored and the
// timestamp field reads back as zero.
module trace_capture_mem
    import trace_capture_buffer_pkg::*;
#(
    parameter int DATA_W  = TC_DEFAULT_DATA_W,
    parameter int CYCLE_W = TC_DEFAULT_CYCLE_W,
    parameter int DEPTH   = TC_DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int REC_W  = CYCLE_W + DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [REC_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [REC_W-1:0]  rdata
);

`ifdef TRACE_CAPTURE_TS_EN
    logic [REC_W-1:0] mem [DEPTH];

    // Store the full {timestamp, payload} record
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
`else
    logic [DATA_W-1:0] mem [DEPTH];
    logic              ts_unused;

    assign ts_unused = ^wdata[REC_W-1:DATA_W];

    // Store the payload only; the timestamp is dropped
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata[DATA_W-1:0];
        end
    end

    assign rdata = {{CYCLE_W{1'b0}}, mem[raddr]};
`endif

endmodule

// File: rtl/trace_capture_buffer.sv
// On-chip trace recorder fed from the WB stage. Arms, waits for a trigger,
// records a post-trigger window into a circular buffer, then freezes and
// streams the contents out oldest-first over a valid/ready port.
// Optional timestamp storage is enabled with the TRACE_CAPTURE_TS_EN macro.
module trace_capture_buffer
    import trace_capture_buffer_pkg::*;
#(
    parameter int DATA_W  = TC_DEFAULT_DATA_W,
    parameter int DEPTH   = TC_DEFAULT_DEPTH,
    parameter int CYCLE_W = TC_DEFAULT_CYCLE_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [1:0]                 trig_mode,
    input  logic [DATA_W-1:0]          trig_value,
    input  logic [DATA_W-1:0]          trig_mask,
    input  logic                       trig_ext,
    input  logic [ADDR_W:0]            post_count,
    input  logic [CYCLE_W-1:0]         cyc_count,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CYCLE_W+DATA_W-1:0]  out_data,
    output logic                       out_last,
    output logic [ADDR_W:0]            entry_count,
    output logic                       triggered,
    output logic                       wrapped,
    output logic                       busy,
    output logic                       done
);

    localparam int REC_W = CYCLE_W + DATA_W;
    localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] POST_MAX = (ADDR_W+1)'(DEPTH - 1);

    trace_cap_state_t  state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   post_remaining;

    logic              capturing;
    logic              wr_en;
    logic              data_match;
    logic              trig_hit;
    logic [ADDR_W:0]   post_load;
    logic [ADDR_W-1:0] wr_ptr_after;
    logic              wrapped_after;
    logic [ADDR_W-1:0] start_rd;
    logic              transfer;
    logic [REC_W-1:0]  rd_data;

    trace_capture_mem #(
        .DATA_W  (DATA_W),
        .CYCLE_W (CYCLE_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({cyc_count, in_data}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Write enable, trigger detection and the readout start pointer. The
    // start pointer accounts for a write landing in the same cycle as the
    // transition into DONE, so the oldest surviving entry is always chosen.
    always_comb begin
        capturing     = (state == TC_ARMED) || (state == TC_TRIGGERED);
        wr_en         = capturing && in_valid;
        data_match    = ((in_data ^ trig_value) & trig_mask) == '0;
        trig_hit      = 1'b0;
        case (trig_mode)
            TRIG_IMM:   trig_hit = in_valid;
            TRIG_MATCH: trig_hit = in_valid && data_match;
            default:    trig_hit = trig_ext;
        endcase
        post_load     = (post_count > POST_MAX) ? POST_MAX : post_count;
        wr_ptr_after  = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        wrapped_after = wrapped || (wr_en && (entry_count == FULL));
        start_rd      = wrapped_after ? wr_ptr_after : '0;
        transfer      = out_valid && out_ready;
    end

    // Capture FSM plus the write pointer, fill level and readout pointer.
    // During DONE entry_count doubles as the count of records left to read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= TC_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            entry_count    <= '0;
            post_remaining <= '0;
            triggered      <= 1'b0;
            wrapped        <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (entry_count == FULL) begin
                    wrapped <= 1'b1;
                end else begin
                    entry_count <= entry_count + 1'b1;
                end
            end

            case (state)
                TC_IDLE: begin
                    if (arm) begin
                        state       <= TC_ARMED;
                        wr_ptr      <= '0;
                        entry_count <= '0;
                        triggered   <= 1'b0;
                        wrapped     <= 1'b0;
                    end
                end

                TC_ARMED: begin
                    if (stop) begin
                        state  <= TC_DONE;
                        rd_ptr <= start_rd;
                    end else if (trig_hit) begin
                        triggered      <= 1'b1;
                        post_remaining <= post_load;
                        if (post_load == '0) begin
                            state  <= TC_DONE;
                            rd_ptr <= start_rd;
                        end else begin
                            state <= TC_TRIGGERED;
                        end
                    end
                end

                TC_TRIGGERED: begin
                    if (stop) begin
                        state  <= TC_DONE;
                        rd_ptr <= start_rd;
                    end else if (wr_en) begin
                        post_remaining <= post_remaining - 1'b1;
                        if (post_remaining == (ADDR_W+1)'(1)) begin
                            state  <= TC_DONE;
                            rd_ptr <= start_rd;
                        end
                    end
                end

                TC_DONE: begin
                    if (arm) begin
                        state       <= TC_ARMED;
                        wr_ptr      <= '0;
                        entry_count <= '0;
                        triggered   <= 1'b0;
                        wrapped     <= 1'b0;
                    end else if (entry_count == '0) begin
                        state <= TC_IDLE;
                    end else if (transfer) begin
                        rd_ptr      <= rd_ptr + 1'b1;
                        entry_count <= entry_count - 1'b1;
                        if (entry_count == (ADDR_W+1)'(1)) begin
                            state <= TC_IDLE;
                        end
                    end
                end

                default: state <= TC_IDLE;
            endcase
        end
    end

    // Status and readout port decoded from the registered state
    always_comb begin
        busy      = (state == TC_ARMED) || (state == TC_TRIGGERED);
        done      = (state == TC_DONE);
        out_valid = done && (entry_count != '0);
        out_last  = out_valid && (entry_count == (ADDR_W+1)'(1));
        out_data  = out_valid ? rd_data : '0;
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed self-checking bench for trace_capture_buffer with DEPTH=8.
// Works with or without TRACE_CAPTURE_TS_EN; the expected timestamp field
// follows the macro.
module tb_trace_capture_buffer;

    localparam int DATA_W  = 16;
    localparam int CYCLE_W = 16;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      arm;
    logic                      stop;
    logic [1:0]                trig_mode;
    logic [DATA_W-1:0]         trig_value;
    logic [DATA_W-1:0]         trig_mask;
    logic                      trig_ext;
    logic [AW:0]               post_count;
    logic [CYCLE_W-1:0]        cyc_count;
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CYCLE_W+DATA_W-1:0] out_data;
    logic                      out_last;
    logic [AW:0]               entry_count;
    logic                      triggered;
    logic                      wrapped;
    logic                      busy;
    logic                      done;

    int errors = 0;
    int checks = 0;

    trace_capture_buffer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CYCLE_W (CYCLE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .stop        (stop),
        .trig_mode   (trig_mode),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .trig_ext    (trig_ext),
        .post_count  (post_count),
        .cyc_count   (cyc_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .entry_count (entry_count),
        .triggered   (triggered),
        .wrapped     (wrapped),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Expected readout word for a payload; the bench drives cyc_count as
    // payload ^ 16'hA5A5 on every record cycle.
    function automatic logic [31:0] exp_word(input logic [15:0] d);
`ifdef TRACE_CAPTURE_TS_EN
        return {d ^ 16'hA5A5, d};
`else
        return {16'h0000, d};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        cyc_count = d ^ 16'hA5A5;
        step();
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        cyc_count = cyc_count + 16'h0101;
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [AW:0] post);
        trig_mode  = mode;
        post_count = post;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (entry_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_entry_count: got %0d expected 0", entry_count); end
        checks++; if ({triggered, wrapped, out_last} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {triggered, wrapped, out_last}); end
    endtask

    task automatic test_immediate();
        logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
        do_arm(2'd0, 4'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL imm_armed_busy: got %b expected 1", busy); end
        send(vals[0]);
        checks++; if (triggered !== 1'b1) begin errors++; $display("[TB] FAIL imm_triggered: got %b expected 1", triggered); end
        send(vals[1]);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL imm_still_busy: got %b expected 1", busy); end
        send(vals[2]);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL imm_done: got %b expected 1", done); end
        checks++; if (entry_count !== 4'd3) begin errors++; $display("[TB] FAIL imm_entry_count: got %0d expected 3", entry_count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("[TB] FAIL imm_wrapped: got %b expected 0", wrapped); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL imm_rd_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exp_word(vals[i])) begin errors++; $display("[TB] FAIL imm_rd_data[%0d]: got %h expected %h", i, out_data, exp_word(vals[i])); end
            checks++; if (out_last !== (i == 2)) begin errors++; $display("[TB] FAIL imm_rd_last[%0d]: got %b expected %b", i, out_last, (i == 2)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL imm_idle_after: got done=%b valid=%b expected 0 0", done, out_valid); end
    endtask

    task automatic test_wrap();
        logic [15:0] vals_a [5] = '{16'h10, 16'h20, 16'h30, 16'h40, 16'h50};
        logic [15:0] vals_b [8] = '{16'h07, 16'h08, 16'h09, 16'h0A, 16'h0B, 16'h0C, 16'h40, 16'h50};
        trig_value = 16'h0040;
        trig_mask  = 16'hFFFF;
        do_arm(2'd1, 4'd1);
        for (int i = 1; i <= 4; i++) send(16'(i * 16));
        checks++; if (done !== 1'b0 || triggered !== 1'b1) begin errors++; $display("[TB] FAIL wrap_after_match: got done=%b trig=%b expected 0 1", done, triggered); end
        send(16'h50);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done: got %b expected 1", done); end
        for (int i = 6; i <= 9; i++) send(16'(i * 16));
        checks++; if (entry_count !== 4'd5) begin errors++; $display("[TB] FAIL wrap_entry_count: got %0d expected 5", entry_count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("[TB] FAIL wrap_wrapped0: got %b expected 0", wrapped); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rd_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exp_word(vals_a[i])) begin errors++; $display("[TB] FAIL wrap_rd_data[%0d]: got %h expected %h", i, out_data, exp_word(vals_a[i])); end
            checks++; if (out_last !== (i == 4)) begin errors++; $display("[TB] FAIL wrap_rd_last[%0d]: got %b expected %b", i, out_last, (i == 4)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got %b expected 0", done); end

        do_arm(2'd1, 4'd1);
        for (int i = 1; i <= 12; i++) send(16'(i));
        send(16'h40);
        send(16'h50);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL wrap2_done: got %b expected 1", done); end
        checks++; if (entry_count !== 4'd8) begin errors++; $display("[TB] FAIL wrap2_entry_count: got %0d expected 8", entry_count); end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("[TB] FAIL wrap2_wrapped: got %b expected 1", wrapped); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap2_rd_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exp_word(vals_b[i])) begin errors++; $display("[TB] FAIL wrap2_rd_data[%0d]: got %h expected %h", i, out_data, exp_word(vals_b[i])); end
            checks++; if (out_last !== (i == 7)) begin errors++; $display("[TB] FAIL wrap2_rd_last[%0d]: got %b expected %b", i, out_last, (i == 7)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b0 || wrapped !== 1'b1) begin errors++; $display("[TB] FAIL wrap2_idle: got done=%b wrapped=%b expected 0 1", done, wrapped); end
    endtask

    task automatic test_clamp();
        do_arm(2'd2, 4'd15);
        trig_ext = 1'b1;
        send(16'hA0);
        trig_ext = 1'b0;
        checks++; if (triggered !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL clamp_trig: got trig=%b busy=%b expected 1 1", triggered, busy); end
        for (int i = 1; i <= 6; i++) send(16'hA0 + 16'(i));
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clamp_busy6: got %b expected 1", busy); end
        send(16'hA7);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL clamp_done7: got %b expected 1", done); end
        for (int i = 8; i <= 10; i++) send(16'hA0 + 16'(i));
        checks++; if (entry_count !== 4'd8 || wrapped !== 1'b0) begin errors++; $display("[TB] FAIL clamp_count: got cnt=%0d wrapped=%b expected 8 0", entry_count, wrapped); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_data !== exp_word(16'hA0 + 16'(i))) begin errors++; $display("[TB] FAIL clamp_rd_data[%0d]: got %h expected %h", i, out_data, exp_word(16'hA0 + 16'(i))); end
            checks++; if (out_last !== (i == 7)) begin errors++; $display("[TB] FAIL clamp_rd_last[%0d]: got %b expected %b", i, out_last, (i == 7)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL clamp_idle: got %b expected 0", done); end
    endtask

    task automatic test_stop_empty();
        do_arm(2'd0, 4'd3);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_done: got done=%b busy=%b expected 1 0", done, busy); end
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL stop_no_valid: got valid=%b data=%h expected 0 0", out_valid, out_data); end
        checks++; if (triggered !== 1'b0 || entry_count !== 4'd0) begin errors++; $display("[TB] FAIL stop_state: got trig=%b cnt=%0d expected 0 0", triggered, entry_count); end
        step();
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stop_idle: got done=%b valid=%b expected 0 0", done, out_valid); end

        // stop beats a matching trigger, and the same-cycle record is kept
        trig_value = 16'h00C1;
        trig_mask  = 16'hFFFF;
        do_arm(2'd1, 4'd3);
        stop = 1'b1;
        send(16'hC1);
        stop = 1'b0;
        checks++; if (done !== 1'b1 || triggered !== 1'b0) begin errors++; $display("[TB] FAIL stop_override: got done=%b trig=%b expected 1 0", done, triggered); end
        checks++; if (entry_count !== 4'd1 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL stop_record_kept: got cnt=%0d last=%b expected 1 1", entry_count, out_last); end
        checks++; if (out_data !== exp_word(16'hC1)) begin errors++; $display("[TB] FAIL stop_record_data: got %h expected %h", out_data, exp_word(16'hC1)); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL stop_record_idle: got %b expected 0", done); end

        // external trigger without a record and a zero window
        do_arm(2'd3, 4'd0);
        trig_ext = 1'b1;
        step();
        trig_ext = 1'b0;
        checks++; if (done !== 1'b1 || triggered !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ext_zero_window: got done=%b trig=%b valid=%b expected 1 1 0", done, triggered, out_valid); end
        step();
        checks++; if (done !== 1'b0 || triggered !== 1'b1) begin errors++; $display("[TB] FAIL ext_zero_idle: got done=%b trig=%b expected 0 1", done, triggered); end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [4] = '{16'hB1, 16'hB2, 16'hB3, 16'hB4};
        do_arm(2'd0, 4'd3);
        for (int i = 0; i < 4; i++) send(vals[i]);
        checks++; if (done !== 1'b1 || entry_count !== 4'd4) begin errors++; $display("[TB] FAIL bp_done: got done=%b cnt=%0d expected 1 4", done, entry_count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_word(vals[1])) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, exp_word(vals[1])); end
            checks++; if (entry_count !== 4'd3) begin errors++; $display("[TB] FAIL bp_hold_count[%0d]: got %0d expected 3", i, entry_count); end
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_data !== exp_word(vals[i])) begin errors++; $display("[TB] FAIL bp_rd_data[%0d]: got %h expected %h", i, out_data, exp_word(vals[i])); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("[TB] FAIL bp_rd_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got %b expected 0", done); end
    endtask

    task automatic test_reset_and_rearm();
        do_arm(2'd0, 4'd5);
        send(16'hD1);
        send(16'hD2);
        checks++; if (busy !== 1'b1 || triggered !== 1'b1) begin errors++; $display("[TB] FAIL rr_triggered: got busy=%b trig=%b expected 1 1", busy, triggered); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({busy, done, triggered, wrapped, out_valid, out_last} !== 6'b0) begin errors++; $display("[TB] FAIL rr_reset_flags: got %b expected 000000", {busy, done, triggered, wrapped, out_valid, out_last}); end
        checks++; if (entry_count !== 4'd0 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL rr_reset_data: got cnt=%0d data=%h expected 0 0", entry_count, out_data); end

        do_arm(2'd0, 4'd2);
        send(16'hE1);
        send(16'hE2);
        send(16'hE3);
        checks++; if (done !== 1'b1 || entry_count !== 4'd3) begin errors++; $display("[TB] FAIL rr_done: got done=%b cnt=%0d expected 1 3", done, entry_count); end
        do_arm(2'd0, 4'd1);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || entry_count !== 4'd0 || triggered !== 1'b0) begin errors++; $display("[TB] FAIL rr_rearm: got busy=%b done=%b cnt=%0d trig=%b expected 1 0 0 0", busy, done, entry_count, triggered); end
        send(16'hF1);
        send(16'hF2);
        checks++; if (done !== 1'b1 || entry_count !== 4'd2) begin errors++; $display("[TB] FAIL rr_fresh_done: got done=%b cnt=%0d expected 1 2", done, entry_count); end
        checks++; if (out_data !== exp_word(16'hF1)) begin errors++; $display("[TB] FAIL rr_fresh_first: got %h expected %h", out_data, exp_word(16'hF1)); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== exp_word(16'hF2) || out_last !== 1'b1) begin errors++; $display("[TB] FAIL rr_fresh_second: got %h last=%b expected %h 1", out_data, out_last, exp_word(16'hF2)); end
        step();
        out_ready = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rr_fresh_idle: got %b expected 0", done); end
    endtask

    initial begin
        rst        = 1'b1;
        arm        = 1'b0;
        stop       = 1'b0;
        trig_mode  = 2'd0;
        trig_value = '0;
        trig_mask  = '0;
        trig_ext   = 1'b0;
        post_count = '0;
        cyc_count  = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        test_reset();
        test_immediate();
        test_wrap();
        test_clamp();
        test_stop_empty();
        test_backpressure();
        test_reset_and_rearm();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
